// File: rtl/color_gen_arbiter.sv
// Round-robin arbiter that time-shares one color generator among NUM_REQ requesters.
// Each transaction runs one grant cycle, then WAIT (with a timeout), then a one-cycle RESP pulse.
module color_gen_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int GEN_LATENCY = 3,
  parameter int TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_tone,
  input  logic [8*NUM_REQ-1:0]  req_effect,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [15:0]           gen_tone,
  output logic [7:0]            gen_effect,
  output logic [15:0]           gen_data,
  input  logic [15:0]           gen_rgb565,
  input  logic                  gen_valid,
  output logic [1:0]            grant_id,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_rgb,
  output logic                  rsp_err,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_ptr, r_gid, w_win, w_idx;
  logic        w_found, w_hit, w_tmo;
  logic [7:0]  r_cnt;
  logic [15:0] r_tone, r_data, r_rgb;
  logic [7:0]  r_effect;
  logic        r_err;
  logic [3:0]  w_req4, w_oh4;
  logic [15:0] w_tone_a [4];
  logic [15:0] w_data_a [4];
  logic [7:0]  w_eff_a  [4];

  // Pad the packed request buses to four lanes so a 2-bit index is always legal.
  assign w_req4 = 4'(req);
  for (genvar i = 0; i < 4; i++) begin : g_lane
    if (i < NUM_REQ) begin : g_on
      assign w_tone_a[i] = req_tone[16*i +: 16];
      assign w_data_a[i] = req_data[16*i +: 16];
      assign w_eff_a[i]  = req_effect[8*i +: 8];
    end else begin : g_off
      assign w_tone_a[i] = '0;
      assign w_data_a[i] = '0;
      assign w_eff_a[i]  = '0;
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = 2'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && w_req4[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_hit = (r_cnt >= 8'(GEN_LATENCY)) && gen_valid;
  assign w_tmo = (r_cnt == 8'(TIMEOUT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_WAIT;
      S_WAIT:  if (w_hit || w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Request fields are sampled only on the grant edge and then held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tone   <= '0;
      r_effect <= '0;
      r_data   <= '0;
      r_gid    <= '0;
      r_ptr    <= 2'(NUM_REQ - 1);
      r_cnt    <= '0;
      r_rgb    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_tone   <= w_tone_a[w_win];
            r_effect <= w_eff_a[w_win];
            r_data   <= w_data_a[w_win];
            r_gid    <= w_win;
            r_ptr    <= w_win;
            r_cnt    <= 8'd1;
          end
        end
        S_WAIT: begin
          if (w_hit) begin
            r_rgb <= gen_rgb565;
            r_err <= 1'b0;
          end else if (w_tmo) begin
            r_rgb <= '0;
            r_err <= 1'b1;
          end else if (r_cnt < 8'(TIMEOUT)) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_oh4      = 4'b0001 << r_gid;
  assign gen_tone   = r_tone;
  assign gen_effect = r_effect;
  assign gen_data   = r_data;
  assign grant_id   = r_gid;
  assign rsp_valid  = (r_state == S_RESP) ? w_oh4[NUM_REQ-1:0] : '0;
  assign rsp_rgb    = r_rgb;
  assign rsp_err    = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/color_gen_arbiter.md
COLOR_GEN_ARBITER -- requirements
Module: color_gen_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters sharing the color generator (supported range 2..4).
REQ-002 Parameter GEN_LATENCY, default 3, cycles from gen_* change to a valid gen_rgb565 (supported range 1..15).
REQ-003 Parameter TIMEOUT, default 16, maximum WAIT cycles before an error response (supported range GEN_LATENCY+1..255).
REQ-004 clk  input  1  system clock (12 MHz), the only clock in the block.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  NUM_REQ  per-requester request level, bit i belongs to requester i.
REQ-007 req_tone  input  16*NUM_REQ  packed note values, slice i = [16i+15:16i].
REQ-008 req_effect  input  8*NUM_REQ  packed effect types, slice i = [8i+7:8i].
REQ-009 req_data  input  16*NUM_REQ  packed effect data, slice i = [16i+15:16i].
REQ-010 gen_tone  output  16  registered note value driven to the color generator.
REQ-011 gen_effect  output  8  registered effect type driven to the color generator.
REQ-012 gen_data  output  16  registered effect data driven to the color generator.
REQ-013 gen_rgb565  input  16  RGB565 result returned by the color generator.
REQ-014 gen_valid  input  1  color-valid flag returned by the color generator.
REQ-015 grant_id  output  2  index of the requester being served, or last served when idle.
REQ-016 rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse for the served requester.
REQ-017 rsp_rgb  output  16  captured RGB565 result, valid only while rsp_valid is non-zero.
REQ-018 rsp_err  output  1  timeout flag, valid only while rsp_valid is non-zero.
REQ-019 busy  output  1  high in the WAIT and RESP states.

Function
REQ-020 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-021 IDLE with req==0: stay IDLE; gen_*, grant_id and the round-robin pointer hold their values.
REQ-022 IDLE with req!=0 in cycle T: grant the first asserted requester searching from pointer+1 upward with wrap-around; latch its slices into gen_tone, gen_effect and gen_data; set grant_id and pointer to the winner; enter WAIT at T+1.
REQ-023 Requester fields SHALL be sampled only in the IDLE grant cycle; later changes to them have no effect on the transaction.
REQ-024 WAIT SHALL count its cycles starting at 1 in cycle T+1.
REQ-025 WAIT, when count>=GEN_LATENCY and gen_valid==1: capture gen_rgb565 into rsp_rgb, clear rsp_err, enter RESP next cycle (nominal RESP cycle = T+GEN_LATENCY+1).
REQ-026 WAIT, when count==TIMEOUT and gen_valid==0: set rsp_rgb=0 and rsp_err=1, enter RESP next cycle.
REQ-027 RESP: rsp_valid = one-hot(grant_id) for exactly one cycle, then IDLE; rsp_valid SHALL be 0 in every other state.
REQ-028 A new grant SHALL NOT occur in RESP; nominal throughput is one transaction per GEN_LATENCY+2 cycles.
REQ-029 A requester holding req high through its RESP is eligible again, but round-robin order SHALL serve all other pending requesters first.
REQ-030 Dropping req during WAIT SHALL NOT abort the transaction; the RESP pulse is still issued.
REQ-031 gen_* SHALL be stable from grant until the next grant, so the generator sees constant inputs through WAIT.
REQ-032 The WAIT counter SHALL saturate at TIMEOUT and never wrap.

Reset
REQ-033 While rst is high: state=IDLE; gen_tone=0, gen_effect=0, gen_data=0, grant_id=0, rsp_valid=0, rsp_rgb=0, rsp_err=0, busy=0; pointer=NUM_REQ-1, so requester 0 has first priority.
REQ-034 rst asserted mid-transaction SHALL discard the transaction with no rsp_valid pulse; the first grant after release follows REQ-033 priority.

Verification
REQ-035 Defaults; req=3'b010, slice1 tone=0x0004, effect=0x06, data=0x1234, gen_valid=1, model drives gen_rgb565=0xF800 -> gen_tone=0x0004, gen_effect=0x06, gen_data=0x1234 from cycle 1; rsp_valid=3'b010, rsp_rgb=0xF800, rsp_err=0 in cycle 4; busy high in cycles 1-4.
REQ-036 After reset, req=3'b111 held -> grants 0,1,2,0 at cycles 0,5,10,15; each rsp_valid pulse is one-hot and lasts one cycle.
REQ-037 Last grant=0, req=3'b101 held -> next grants 2 then 0, alternating; requester 1 never pulsed.
REQ-038 gen_valid held 0 -> WAIT lasts 16 cycles; RESP in cycle 17 with rsp_err=1, rsp_rgb=0x0000; then IDLE.
REQ-039 rst pulsed in WAIT cycle 2 -> all outputs 0 in the same cycle; no rsp_valid pulse; with req=3'b110 after release, first grant=1.
REQ-040 Requester 0 changes its tone and drops req during WAIT -> gen_tone keeps the originally latched value; rsp_valid=3'b001 still pulses in cycle 4.
